// File: rtl/storage_arb_pkg.sv
// Shared types and defaults for the storage arbiter and its clear sequencer.
package storage_arb_pkg;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_AW    = 12;
  localparam int DEF_DW    = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CLEAR
  } state_t;

endpackage

// File: rtl/storage_clear_seq.sv
// Zero-sweep address counter: runs DEPTH cycles after start, flags the final word.
module storage_clear_seq
  import storage_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          last
);

  logic [CW-1:0] count_reg;
  logic          active_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      count_reg  <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (last) begin
        active_reg <= 1'b0;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign count  = count_reg;
  assign active = active_reg;
  assign last   = active_reg && (count_reg == CW'(DEPTH - 1));

endmodule

// File: rtl/storage_arbiter.sv
// Two-port round-robin arbiter and clear sequencer in front of the storage memory.
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_done,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_datain,
  output logic          mem_str,
  output logic          mem_ld,
  input  logic [DW-1:0] mem_dataout
);

  localparam int CW = $clog2(DEPTH);

  state_t        state_reg;
  logic          last_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          str_reg;
  logic          ld_reg;
  logic          err_reg;
  logic          a_gnt_reg;
  logic          b_gnt_reg;

  logic [CW-1:0] clr_count;
  logic          clr_active;
  logic          clr_last;
  logic          clr_start;

  logic          grant_any;
  logic          grant_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          sel_oor;

  assign clr_start = (state_reg == IDLE) && clear_req;

  storage_clear_seq #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_clear_seq (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (clr_start),
    .count  (clr_count),
    .active (clr_active),
    .last   (clr_last)
  );

  // B wins when it is alone, or on a tie when A was served last.
  always_comb begin
    grant_any = a_req | b_req;
    grant_b   = b_req && (!a_req || (last_reg == PORT_A));
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    sel_we    = grant_b ? b_we    : a_we;
    sel_oor   = (sel_addr >= AW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      last_reg  <= PORT_B;
      addr_reg  <= '0;
      wdata_reg <= '0;
      str_reg   <= 1'b0;
      ld_reg    <= 1'b0;
      err_reg   <= 1'b0;
      a_gnt_reg <= 1'b0;
      b_gnt_reg <= 1'b0;
    end else begin
      str_reg   <= 1'b0;
      ld_reg    <= 1'b0;
      err_reg   <= 1'b0;
      a_gnt_reg <= 1'b0;
      b_gnt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear_req) begin
            state_reg <= CLEAR;
          end else if (grant_any) begin
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            str_reg   <= sel_we && !sel_oor;
            ld_reg    <= !sel_we && !sel_oor;
            err_reg   <= sel_oor;
            a_gnt_reg <= !grant_b;
            b_gnt_reg <= grant_b;
            last_reg  <= grant_b ? PORT_B : PORT_A;
            state_reg <= ACCESS;
          end
        end
        ACCESS: state_reg <= IDLE;
        CLEAR: begin
          // Track the sweep so the memory bus holds its last value afterwards.
          addr_reg  <= AW'(clr_count);
          wdata_reg <= '0;
          if (clr_last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = clr_active;
  assign clear_done  = clr_last;
  assign mem_address = clr_active ? AW'(clr_count) : addr_reg;
  assign mem_datain  = clr_active ? '0 : wdata_reg;
  assign mem_str     = str_reg | clr_active;
  assign mem_ld      = ld_reg;

  assign a_gnt   = a_gnt_reg;
  assign b_gnt   = b_gnt_reg;
  assign a_err   = a_gnt_reg & err_reg;
  assign b_err   = b_gnt_reg & err_reg;
  assign a_rdata = (a_gnt_reg && ld_reg) ? mem_dataout : '0;
  assign b_rdata = (b_gnt_reg && ld_reg) ? mem_dataout : '0;

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench for storage_arbiter with a behavioural storage and reference model.
module tb_storage_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        a_req, a_we, b_req, b_we, clear_req;
  logic [11:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_err, b_err, busy, clear_done, mem_str, mem_ld;
  logic [31:0] a_rdata, b_rdata, mem_datain, mem_dataout;
  logic [11:0] mem_address;

  logic [31:0] stor_mem [0:63];
  logic [31:0] ref_mem  [0:63];
  bit          last_win;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  always #5 clk = ~clk;

  storage_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_err(b_err),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_str(mem_str), .mem_ld(mem_ld), .mem_dataout(mem_dataout)
  );

  // Storage: writes on the negedge, combinational read.
  always @(negedge clk)
    if (mem_str && mem_address < 12'd64) stor_mem[mem_address[5:0]] <= mem_datain;
  assign mem_dataout = (mem_address < 12'd64) ? stor_mem[mem_address[5:0]] : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit port, input bit we, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic st, output logic ld, output int lat);
    lat = -1; rd = '0; er = 1'b0; st = 1'b0; ld = 1'b0;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int i = 1; i <= 50; i++) begin
      step();
      if ((port ? b_gnt : a_gnt) === 1'b1) begin
        rd = port ? b_rdata : a_rdata;
        er = port ? b_err : a_err;
        st = mem_str; ld = mem_ld; lat = i;
        break;
      end
    end
    if (port) b_req = 0; else a_req = 0;
    $display("txn port=%s we=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d",
             port ? "B" : "A", we, addr, wd, rd, er, lat);
  endtask

  task automatic test_reset();
    logic [115:0] outs;
    clr_n = 0; a_req = 1; a_we = 1; a_addr = 12'd5; a_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      outs = {a_gnt, b_gnt, a_err, b_err, busy, clear_done, mem_str, mem_ld,
              mem_address, mem_datain, a_rdata, b_rdata};
      chk_cnt++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
      else pass_cnt++;
    end
    a_req = 0;
    step();
    clr_n = 1;
    last_win = 1;
    step();
    chk_cnt++;
    if ({a_gnt, b_gnt, busy, mem_str, mem_ld} !== 5'b0)
      $display("FAIL reset_release_idle: got %b expected 00000", {a_gnt, b_gnt, busy, mem_str, mem_ld});
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [31:0] rd; logic er, st, ld; int lat;
    access(0, 1, 12'd5, 32'hDEAD_BEEF, rd, er, st, ld, lat);
    ref_mem[5] = 32'hDEAD_BEEF; last_win = 0;
    chk_cnt++;
    if ({lat == 1, st, ld, er} !== 4'b1100)
      $display("FAIL single_store: lat=%0d str=%b ld=%b err=%b expected lat=1 str=1 ld=0 err=0", lat, st, ld, er);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (a_gnt !== 1'b0) $display("FAIL single_gnt_pulse: got %b expected 0", a_gnt);
    else pass_cnt++;
    chk_cnt++;
    if (stor_mem[5] !== ref_mem[5]) $display("FAIL single_mem: got %h expected %h", stor_mem[5], ref_mem[5]);
    else pass_cnt++;
    access(0, 0, 12'd5, 32'h0, rd, er, st, ld, lat);
    chk_cnt++;
    if ({lat == 1, ld, st, er} !== 4'b1100 || rd !== ref_mem[5])
      $display("FAIL single_load: rdata=%h lat=%0d ld=%b expected rdata=%h lat=1 ld=1", rd, lat, ld, ref_mem[5]);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [31:0] da, db;
    int next_s; bit winner; int ngr;
    da = $urandom; db = $urandom;
    clr_n = 0;
    a_req = 1; a_we = 1; a_addr = 12'd1; a_wdata = da;
    b_req = 1; b_we = 1; b_addr = 12'd2; b_wdata = db;
    step(); step();
    clr_n = 1; last_win = 1;
    next_s = 1; winner = ~last_win; ngr = 0;
    for (int s = 1; s <= 16; s++) begin
      step();
      chk_cnt++;
      if ({a_gnt, b_gnt} !== {s == next_s && winner == 0, s == next_s && winner == 1})
        $display("FAIL contention_order step %0d: got a=%b b=%b expected a=%b b=%b", s, a_gnt, b_gnt,
                 s == next_s && winner == 0, s == next_s && winner == 1);
      else pass_cnt++;
      if (s == next_s) begin
        if (winner) ref_mem[2] = db; else ref_mem[1] = da;
        last_win = winner; winner = ~winner; next_s += 2; ngr++;
      end
    end
    a_req = 0; b_req = 0;
    step();
    chk_cnt++;
    if (stor_mem[1] !== ref_mem[1] || stor_mem[2] !== ref_mem[2])
      $display("FAIL contention_mem: got %h/%h expected %h/%h", stor_mem[1], stor_mem[2], ref_mem[1], ref_mem[2]);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, v0; logic er, st, ld; int lat;
    v0 = $urandom | 32'h1;
    access(0, 1, 12'd0, v0, rd, er, st, ld, lat);
    ref_mem[0] = v0; last_win = 0;
    access(1, 1, 12'd64, $urandom, rd, er, st, ld, lat);
    last_win = 1;
    chk_cnt++;
    if ({lat > 0, er, st} !== 3'b110)
      $display("FAIL oor_store: lat=%0d err=%b str=%b expected gnt err=1 str=0", lat, er, st);
    else pass_cnt++;
    access(1, 0, 12'd0, 32'h0, rd, er, st, ld, lat);
    chk_cnt++;
    if (rd !== ref_mem[0] || er !== 1'b0) $display("FAIL oor_mem_unchanged: got %h expected %h", rd, ref_mem[0]);
    else pass_cnt++;
    access(1, 0, 12'd100, 32'h0, rd, er, st, ld, lat);
    chk_cnt++;
    if ({lat > 0, er, ld} !== 3'b110 || rd !== 32'h0)
      $display("FAIL oor_load: rdata=%h err=%b ld=%b expected rdata=0 err=1 ld=0", rd, er, ld);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [31:0] rd; logic er, st, ld; int lat;
    int busy_cnt, done_cnt, fall, gnt_s;
    for (int i = 0; i < DEPTH; i++) begin
      access(i[0], 1, 12'(i), $urandom | 32'h1, rd, er, st, ld, lat);
      last_win = i[0];
    end
    step();
    busy_cnt = 0; done_cnt = 0; fall = -1; gnt_s = -1;
    clear_req = 1;
    for (int s = 1; s <= 200; s++) begin
      step();
      if (s == 1) begin
        clear_req = 0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL clear_busy_start: got %b expected 1", busy);
        else pass_cnt++;
      end
      if (busy === 1'b1) begin
        busy_cnt++;
        chk_cnt++;
        if ({mem_str, mem_address, mem_datain, a_gnt} !== {1'b1, 12'(busy_cnt - 1), 32'h0, 1'b0})
          $display("FAIL clear_sweep cycle %0d: str=%b addr=%0d data=%h gnt=%b expected str=1 addr=%0d data=0 gnt=0",
                   busy_cnt, mem_str, mem_address, mem_datain, a_gnt, busy_cnt - 1);
        else pass_cnt++;
      end else if (fall < 0 && busy_cnt > 0) fall = s;
      if (clear_done === 1'b1) begin
        done_cnt++;
        chk_cnt++;
        if (busy_cnt !== DEPTH) $display("FAIL clear_done_pos: got cycle %0d expected %0d", busy_cnt, DEPTH);
        else pass_cnt++;
      end
      if (s == 5) begin a_req = 1; a_we = 0; a_addr = 12'd7; end
      if (a_gnt === 1'b1) begin gnt_s = s; rd = a_rdata; a_req = 0; break; end
    end
    last_win = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    chk_cnt++;
    if (busy_cnt !== DEPTH || done_cnt !== 1)
      $display("FAIL clear_busy_len: busy=%0d done=%0d expected busy=%0d done=1", busy_cnt, done_cnt, DEPTH);
    else pass_cnt++;
    chk_cnt++;
    if (fall < 0 || gnt_s < fall + 1 || rd !== 32'h0)
      $display("FAIL clear_pending_gnt: gnt step %0d busy fell %0d rdata=%h expected later gnt and rdata=0", gnt_s, fall, rd);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      access(i[0], 0, 12'(i), 32'h0, rd, er, st, ld, lat);
      last_win = i[0];
      chk_cnt++;
      if (rd !== ref_mem[i] || lat < 1) $display("FAIL clear_readback addr %0d: got %h expected %h", i, rd, ref_mem[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [11:0] ad [2]; logic [31:0] wd [2]; bit wr [2]; bit want [2];
    bit exp_next, g; int nreq, ngr, first_s;
    logic [33:0] got, exp;
    for (int it = 0; it < 40; it++) begin
      step();
      nreq = 0; ngr = 0; first_s = 0;
      for (int p = 0; p < 2; p++) begin
        want[p] = 1'b0;
        ad[p] = 12'($urandom_range(0, 71)); wd[p] = $urandom; wr[p] = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(1, 3))
        1: want[0] = 1;
        2: want[1] = 1;
        default: begin want[0] = 1; want[1] = 1; end
      endcase
      if (want[0]) begin a_req = 1; a_we = wr[0]; a_addr = ad[0]; a_wdata = wd[0]; nreq++; end
      if (want[1]) begin b_req = 1; b_we = wr[1]; b_addr = ad[1]; b_wdata = wd[1]; nreq++; end
      exp_next = (want[0] && want[1]) ? ~last_win : want[1];
      for (int s = 1; s <= 12; s++) begin
        step();
        if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
          g = (b_gnt === 1'b1);
          chk_cnt++;
          if ({a_gnt, b_gnt} === 2'b11 || g !== exp_next || s !== (ngr == 0 ? 1 : 3))
            $display("FAIL random_arb it %0d: a=%b b=%b step %0d expected port %0d at step %0d",
                     it, a_gnt, b_gnt, s, exp_next, ngr == 0 ? 1 : 3);
          else pass_cnt++;
          got = {g ? b_rdata : a_rdata, g ? b_err : a_err, mem_str};
          exp = {(!wr[g] && ad[g] < 64) ? ref_mem[ad[g][5:0]] : 32'h0, ad[g] >= 64, wr[g] && ad[g] < 64};
          chk_cnt++;
          if (got !== exp || mem_ld !== (!wr[g] && ad[g] < 64))
            $display("FAIL random_data it %0d port %0d: got %h ld=%b expected %h ld=%b", it, g, got, mem_ld, exp,
                     !wr[g] && ad[g] < 64);
          else pass_cnt++;
          $display("txn it=%0d port=%0d we=%0d addr=%0d rdata=%h err=%b", it, g, wr[g], ad[g], got[33:2], got[1]);
          if (wr[g] && ad[g] < 64) ref_mem[ad[g][5:0]] = wd[g];
          if (g) b_req = 0; else a_req = 0;
          last_win = g; exp_next = ~g; ngr++;
          if (ngr == nreq) break;
        end
      end
      chk_cnt++;
      if (ngr !== nreq) $display("FAIL random_timeout it %0d: got %0d grants expected %0d", it, ngr, nreq);
      else pass_cnt++;
      a_req = 0; b_req = 0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] rd; logic er, st, ld; int lat; int busy_cnt; logic [11:0] ra;
    step();
    busy_cnt = 0;
    clear_req = 1;
    for (int s = 1; s <= 40; s++) begin
      step();
      clear_req = 0;
      if (busy === 1'b1) busy_cnt++;
      if (busy_cnt == 10) break;
    end
    clr_n = 0;
    step();
    chk_cnt++;
    if ({busy, mem_str, clear_done} !== 3'b000 || busy_cnt != 10)
      $display("FAIL midsweep_abort: busy=%b str=%b done=%b reached %0d expected all 0 after cycle 10",
               busy, mem_str, clear_done, busy_cnt);
    else pass_cnt++;
    clr_n = 1; last_win = 1;
    step();
    clear_req = 1;
    step();
    clear_req = 0;
    chk_cnt++;
    if ({busy, mem_str, mem_address} !== {1'b1, 1'b1, 12'd0})
      $display("FAIL midsweep_restart: busy=%b str=%b addr=%0d expected busy=1 str=1 addr=0", busy, mem_str, mem_address);
    else pass_cnt++;
    busy_cnt = 1;
    for (int s = 0; s < 100; s++) begin
      step();
      if (busy !== 1'b1) break;
      busy_cnt++;
    end
    chk_cnt++;
    if (busy_cnt !== DEPTH) $display("FAIL midsweep_len: got %0d expected %0d", busy_cnt, DEPTH);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ra = 12'($urandom_range(0, DEPTH - 1));
      access(1'(i), 0, ra, 32'h0, rd, er, st, ld, lat);
      last_win = 1'(i);
      chk_cnt++;
      if (rd !== ref_mem[ra[5:0]] || lat < 1) $display("FAIL midsweep_readback addr %0d: got %h expected 0", ra, rd);
      else pass_cnt++;
    end
  endtask

  initial begin
    clr_n = 0; clear_req = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_out_of_range();
    test_clear();
    test_random();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/storage_arbiter.md
# storage_arbiter

Sequencer and two-port arbiter in front of the `storage` data memory: the CPU data port (A) and the program/debug loader port (B) share the memory's single address/write port. Both ports use a req/gnt handshake with round-robin fairness. A hardware clear sweep zeroes the memory one word per cycle. The `storage` `clr` input is tied to 0 at integration; all clearing goes through this block.

## Interface
- `DEPTH`, 64, number of implemented words; legal addresses are 0..DEPTH-1.
- `AW`, 12, address width.
- `DW`, 32, data width.

- `clk`  in  1  clock; all state updates on posedge.
- `clr_n`  in  1  reset, **synchronous, active-low**.
- `a_req`, `b_req`  in  1  access request; held until the matching gnt.
- `a_we`, `b_we`  in  1  1 = store, 0 = load; held with req.
- `a_addr`, `b_addr`  in  AW  word address; held with req.
- `a_wdata`, `b_wdata`  in  DW  store data; held with req.
- `a_gnt`, `b_gnt`  out  1  one-cycle pulse; the access happens in this cycle.
- `a_rdata`, `b_rdata`  out  DW  load data, valid while the matching gnt is 1; otherwise 0.
- `a_err`, `b_err`  out  1  pulses with gnt when the address is ≥ DEPTH.
- `clear_req`  in  1  level; requests a full zero sweep.
- `busy`  out  1  high while in CLEAR.
- `clear_done`  out  1  one-cycle pulse in the final sweep cycle.
- `mem_address`  out  AW  drives the `storage` address input.
- `mem_datain`  out  DW  drives the `storage` datain input.
- `mem_str`  out  1  drives the `storage` str input.
- `mem_ld`  out  1  drives the `storage` ld input.
- `mem_dataout`  in  DW  from the `storage` dataout output.

## Operation
- **FSM states:** IDLE, ACCESS, CLEAR. Reset state is IDLE.
- **IDLE arbitration priority:**
  1. `clear_req`: go to CLEAR with the sweep counter at 0.
  2. Exactly one req: grant that port.
  3. Both reqs: grant the port not granted last. `last` resets to B, so A wins the first tie.
- **Grant:** register the port's addr/we/wdata into `mem_*`, update `last`, go to ACCESS.
- **ACCESS:** lasts one cycle.
  - gnt is 1 for the granted port.
  - Load: `mem_ld`=1 and rdata = `mem_dataout`.
  - Store: `mem_str`=1.
  - Always returns to IDLE; req is not sampled in ACCESS.
- **Out-of-range address (≥ DEPTH):**
  - gnt and err pulse as usual.
  - `mem_str` and `mem_ld` stay 0.
  - rdata = 0.
  - Memory is unchanged.
- **CLEAR:** each cycle drives `mem_str`=1, `mem_datain`=0, `mem_address`=counter, then increments the counter.
  - At counter = DEPTH-1: pulse `clear_done` and return to IDLE.
  - reqs arriving during the sweep stay pending and are arbitrated normally in IDLE afterwards.
  - `clear_req` still high on return starts another sweep.
- **Reset:** clr_n=0 aborts anything in progress, including a sweep. Memory contents after an aborted sweep are undefined.
- **Output reset values:** all 0, including `mem_address`, `mem_datain`, `mem_str`, `mem_ld`, gnt, rdata, err, `busy`, `clear_done`.

## Timing
- A request sampled at posedge P0 in IDLE is granted in the cycle following P0.
  - `storage` writes on the negedge inside that cycle, so `mem_*` come from registers and are stable at the negedge.
  - rdata is combinational from `mem_dataout` in the same cycle.
- The requester sees gnt at P1 and may change or drop req after P1. The arbiter samples again at P2.
  - Maximum rate is one access per 2 cycles.
  - With both ports requesting continuously, grants alternate A, B, A, B.
- **Sweep:** DEPTH cycles. `busy` is high for exactly DEPTH cycles, starting the cycle after `clear_req` is sampled.
- A request that arrives during a sweep is granted no earlier than 1 cycle after `busy` falls.
- Outside ACCESS and CLEAR: `mem_str`=`mem_ld`=0. `mem_address` and `mem_datain` hold their last values.

## Structure
- **Package `storage_arb_pkg`:**
  - State enum `{IDLE, ACCESS, CLEAR}`.
  - Port index constants `PORT_A`=0, `PORT_B`=1.
  - Default `DEPTH`, `AW`, `DW`.
- **Sub-module `storage_clear_seq`:** sweep counter, `busy` and `clear_done`.
  - Inputs: `start`, `clk`, `clr_n`.
  - Outputs: counter value, `active`, `last`.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Reset:** hold clr_n=0 for 3 cycles with `a_req`=1 → no gnt; all outputs 0.
- **Single store/load:** A stores 0xDEADBEEF to addr 5 → `a_gnt` pulses once with `mem_str`=1. A then loads addr 5 → `a_rdata`=0xDEADBEEF in the gnt cycle.
- **Contention:** A and B request continuously from reset (A to addr 1, B to addr 2) → gnt order A, B, A, B; gnts 2 cycles apart; each write lands at the correct address.
- **Out of range:** B stores to addr 64 → `b_gnt` and `b_err` pulse; `mem_str` stays 0; a later load of addr 0 returns the unchanged value.
- **Clear with pending request:**
  - Preload words 0..63 with nonzero values, pulse `clear_req`, then raise `a_req` during the sweep.
  - `busy` is high for exactly 64 cycles and `clear_done` pulses in the last one.
  - `a_gnt` arrives after `busy` falls; every word reads back 0.
- **Reset mid-sweep:** clr_n=0 at sweep cycle 10 → FSM returns to IDLE and `busy` is 0 next cycle; a following `clear_req` restarts the sweep at address 0.
